// File: rtl/asic_ram_arbiter.sv
// rtl/asic_ram_arbiter.sv - ASIC RAM arbiter for CPU page, sprite fetcher and DMA sound channels
module asic_ram_arbiter #(
    parameter int SPR_BURST_MAX = 4,
    parameter int ADDR_W        = 14
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  plus_mode,
    input  logic                  asic_valid,
    input  logic                  page_en,
    input  logic [15:0]           cpu_addr,
    input  logic [7:0]            cpu_din,
    input  logic                  cpu_rd,
    input  logic                  cpu_wr,
    output logic [7:0]            cpu_dout,
    output logic                  cpu_wait,
    input  logic                  spr_req,
    input  logic [ADDR_W-1:0]     spr_addr,
    output logic                  spr_ack,
    output logic [7:0]            spr_data,
    input  logic [2:0]            dma_req,
    input  logic [3*ADDR_W-1:0]   dma_addr,
    output logic [2:0]            dma_ack,
    output logic [7:0]            dma_data,
    output logic [ADDR_W-1:0]     asic_ram_addr,
    output logic                  asic_ram_rd,
    output logic                  asic_ram_wr,
    output logic [7:0]            asic_ram_din,
    input  logic [7:0]            asic_ram_q
);
    localparam int BW = $clog2(SPR_BURST_MAX + 1);

    // Identifies which requester owns the RAM access issued in the previous cycle
    typedef enum logic [2:0] {
        TAG_NONE   = 3'd0,
        TAG_SPR    = 3'd1,
        TAG_CPU_RD = 3'd2,
        TAG_CPU_WR = 3'd3,
        TAG_DMA0   = 3'd4,
        TAG_DMA1   = 3'd5,
        TAG_DMA2   = 3'd6
    } tag_t;

    logic              w_en;
    logic              w_hit;
    logic              w_rd_rise;
    logic              w_wr_rise;
    logic              w_cpu_edge;
    logic              w_spr_elig;
    logic              w_cpu_elig;
    logic              w_spr_skip;
    logic              w_any_req;
    logic [2:0]        w_dma_elig;
    logic [2:0]        w_dma_rot;
    logic [1:0]        w_dma_off;
    logic [2:0]        w_pick_sum;
    logic [1:0]        w_dma_pick;
    tag_t              w_gnt;

    logic              r_cpu_rd_q;
    logic              r_cpu_wr_q;
    logic              r_cpu_pend;
    logic              r_cpu_is_wr;
    logic [ADDR_W-1:0] r_cpu_addr;
    logic [7:0]        r_cpu_din;
    logic [7:0]        r_cpu_dout;
    tag_t              r_tag;
    logic [1:0]        r_ptr;
    logic [BW-1:0]     r_burst;

    assign w_en       = plus_mode & asic_valid & page_en;
    assign w_hit      = w_en & (cpu_addr[15:14] == 2'b01);
    assign w_rd_rise  = cpu_rd & ~r_cpu_rd_q;
    assign w_wr_rise  = cpu_wr & ~r_cpu_wr_q;
    assign w_cpu_edge = w_hit & (w_rd_rise | w_wr_rise);

    // The requester whose access is completing this cycle cannot be granted again
    assign w_spr_elig    = spr_req & (r_tag != TAG_SPR);
    assign w_cpu_elig    = r_cpu_pend & (r_tag != TAG_CPU_RD) & (r_tag != TAG_CPU_WR);
    assign w_dma_elig[0] = dma_req[0] & (r_tag != TAG_DMA0);
    assign w_dma_elig[1] = dma_req[1] & (r_tag != TAG_DMA1);
    assign w_dma_elig[2] = dma_req[2] & (r_tag != TAG_DMA2);
    assign w_any_req     = spr_req | r_cpu_pend | (|dma_req);
    assign w_spr_skip    = (r_burst >= BW'(SPR_BURST_MAX)) & (w_cpu_elig | (|w_dma_elig));

    // Round-robin DMA pick: rotate eligibility so bit 0 is the channel at the pointer
    always_comb begin
        case (r_ptr)
            2'd1:    w_dma_rot = {w_dma_elig[0], w_dma_elig[2], w_dma_elig[1]};
            2'd2:    w_dma_rot = {w_dma_elig[1], w_dma_elig[0], w_dma_elig[2]};
            default: w_dma_rot = w_dma_elig;
        endcase
        if (w_dma_rot[0])      w_dma_off = 2'd0;
        else if (w_dma_rot[1]) w_dma_off = 2'd1;
        else                   w_dma_off = 2'd2;
        w_pick_sum = {1'b0, r_ptr} + {1'b0, w_dma_off};
        w_dma_pick = (w_pick_sum >= 3'd3) ? 2'(w_pick_sum - 3'd3) : w_pick_sum[1:0];
    end

    // Fixed priority sprite > CPU > DMA, with the sprite yielding one slot after a full burst
    always_comb begin
        w_gnt = TAG_NONE;
        if (!reset && w_en) begin
            if (w_spr_elig && !w_spr_skip) begin
                w_gnt = TAG_SPR;
            end else if (w_cpu_elig) begin
                w_gnt = r_cpu_is_wr ? TAG_CPU_WR : TAG_CPU_RD;
            end else if (|w_dma_elig) begin
                case (w_dma_pick)
                    2'd0:    w_gnt = TAG_DMA0;
                    2'd1:    w_gnt = TAG_DMA1;
                    default: w_gnt = TAG_DMA2;
                endcase
            end
        end
    end

    // Drive the RAM port for the access granted this cycle
    always_comb begin
        asic_ram_addr = '0;
        asic_ram_rd   = 1'b0;
        asic_ram_wr   = 1'b0;
        asic_ram_din  = 8'h00;
        case (w_gnt)
            TAG_SPR: begin
                asic_ram_addr = spr_addr;
                asic_ram_rd   = 1'b1;
            end
            TAG_CPU_RD: begin
                asic_ram_addr = r_cpu_addr;
                asic_ram_rd   = 1'b1;
            end
            TAG_CPU_WR: begin
                asic_ram_addr = r_cpu_addr;
                asic_ram_wr   = 1'b1;
                asic_ram_din  = r_cpu_din;
            end
            TAG_DMA0: begin
                asic_ram_addr = dma_addr[ADDR_W-1:0];
                asic_ram_rd   = 1'b1;
            end
            TAG_DMA1: begin
                asic_ram_addr = dma_addr[2*ADDR_W-1:ADDR_W];
                asic_ram_rd   = 1'b1;
            end
            TAG_DMA2: begin
                asic_ram_addr = dma_addr[3*ADDR_W-1:2*ADDR_W];
                asic_ram_rd   = 1'b1;
            end
            default: begin
                asic_ram_rd   = 1'b0;
            end
        endcase
    end

    // In-flight tag, round-robin pointer and sprite burst counter
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_tag   <= TAG_NONE;
            r_ptr   <= 2'd0;
            r_burst <= '0;
        end else begin
            r_tag <= w_gnt;
            case (w_gnt)
                TAG_DMA0: r_ptr <= 2'd1;
                TAG_DMA1: r_ptr <= 2'd2;
                TAG_DMA2: r_ptr <= 2'd0;
                default:  r_ptr <= r_ptr;
            endcase
            if (w_gnt == TAG_SPR) begin
                if (r_burst < BW'(SPR_BURST_MAX)) begin
                    r_burst <= r_burst + BW'(1);
                end
            end else if (w_gnt != TAG_NONE || !w_any_req) begin
                r_burst <= '0;
            end
        end
    end

    // CPU strobe history, access capture, and read data latch
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_cpu_rd_q  <= 1'b0;
            r_cpu_wr_q  <= 1'b0;
            r_cpu_pend  <= 1'b0;
            r_cpu_is_wr <= 1'b0;
            r_cpu_addr  <= '0;
            r_cpu_din   <= 8'h00;
            r_cpu_dout  <= 8'h00;
        end else begin
            r_cpu_rd_q <= cpu_rd;
            r_cpu_wr_q <= cpu_wr;
            // A new edge wins over retiring the previous access in the same cycle
            if (w_cpu_edge) begin
                r_cpu_pend  <= 1'b1;
                r_cpu_addr  <= cpu_addr[ADDR_W-1:0];
                r_cpu_din   <= cpu_din;
                r_cpu_is_wr <= w_wr_rise;
            end else if (!w_en || w_gnt == TAG_CPU_RD || w_gnt == TAG_CPU_WR) begin
                r_cpu_pend  <= 1'b0;
            end
            if (r_tag == TAG_CPU_RD) begin
                r_cpu_dout <= asic_ram_q;
            end
        end
    end

    // Completion-cycle acks and data routing; everything forced low while in reset
    always_comb begin
        cpu_wait = !reset && (w_cpu_edge || r_cpu_pend);
        spr_ack  = !reset && (r_tag == TAG_SPR);
        dma_ack  = 3'b000;
        if (!reset) begin
            dma_ack = {r_tag == TAG_DMA2, r_tag == TAG_DMA1, r_tag == TAG_DMA0};
        end
        spr_data = spr_ack ? asic_ram_q : 8'h00;
        dma_data = (|dma_ack) ? asic_ram_q : 8'h00;
        if (reset)                   cpu_dout = 8'h00;
        else if (r_tag == TAG_CPU_RD) cpu_dout = asic_ram_q;
        else                          cpu_dout = r_cpu_dout;
    end
endmodule

// File: tb/tb_asic_ram_arbiter.sv
// tb/tb_asic_ram_arbiter.sv - directed self-checking bench for asic_ram_arbiter
module tb_asic_ram_arbiter;
    logic        clk_sys    = 1'b0;
    logic        reset      = 1'b1;
    logic        plus_mode  = 1'b0;
    logic        asic_valid = 1'b0;
    logic        page_en    = 1'b0;
    logic [15:0] cpu_addr   = 16'h0000;
    logic [7:0]  cpu_din    = 8'h00;
    logic        cpu_rd     = 1'b0;
    logic        cpu_wr     = 1'b0;
    logic [7:0]  cpu_dout;
    logic        cpu_wait;
    logic        spr_req    = 1'b0;
    logic [13:0] spr_addr   = 14'h0000;
    logic        spr_ack;
    logic [7:0]  spr_data;
    logic [2:0]  dma_req    = 3'b000;
    logic [41:0] dma_addr   = 42'h0;
    logic [2:0]  dma_ack;
    logic [7:0]  dma_data;
    logic [13:0] asic_ram_addr;
    logic        asic_ram_rd;
    logic        asic_ram_wr;
    logic [7:0]  asic_ram_din;
    logic [7:0]  asic_ram_q;

    logic [7:0]  mem [16384];
    int          total = 0;
    int          bad   = 0;
    logic [13:0] dma_a [3];
    logic [7:0]  dma_d [3];

    asic_ram_arbiter #(.SPR_BURST_MAX(4), .ADDR_W(14)) dut (
        .clk_sys(clk_sys), .reset(reset), .plus_mode(plus_mode),
        .asic_valid(asic_valid), .page_en(page_en),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_dout(cpu_dout), .cpu_wait(cpu_wait),
        .spr_req(spr_req), .spr_addr(spr_addr), .spr_ack(spr_ack), .spr_data(spr_data),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_ack(dma_ack), .dma_data(dma_data),
        .asic_ram_addr(asic_ram_addr), .asic_ram_rd(asic_ram_rd), .asic_ram_wr(asic_ram_wr),
        .asic_ram_din(asic_ram_din), .asic_ram_q(asic_ram_q)
    );

    always #5 clk_sys = ~clk_sys;

    // Single-port RAM macro model with one-cycle read latency
    always @(posedge clk_sys) begin
        if (asic_ram_wr) mem[asic_ram_addr] <= asic_ram_din;
        if (asic_ram_rd) asic_ram_q <= mem[asic_ram_addr];
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_wait"}, cpu_wait, 0);
        check({tag, "_rd"}, asic_ram_rd, 0);
        check({tag, "_wr"}, asic_ram_wr, 0);
    endtask

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog expired");
    end

    initial begin
        for (int a = 0; a < 16384; a++) mem[a] = 8'(a) ^ 8'hFF;
        mem[14'h0010] = 8'h5A;
        mem[14'h0020] = 8'h3C;
        mem[14'h2000] = 8'hA7;
        mem[14'h0100] = 8'h11;
        mem[14'h0200] = 8'h22;
        mem[14'h0300] = 8'h33;
        dma_a[0] = 14'h0100; dma_a[1] = 14'h0200; dma_a[2] = 14'h0300;
        dma_d[0] = 8'h11;    dma_d[1] = 8'h22;    dma_d[2] = 8'h33;

        // Reset with live requests: every output must stay low
        plus_mode = 1'b1; asic_valid = 1'b1; page_en = 1'b1;
        cpu_addr = 16'h4010; cpu_rd = 1'b1; spr_req = 1'b1; dma_req = 3'b111;
        tick(); tick();
        #1;
        check("rst_wait", cpu_wait, 0);
        check("rst_dout", cpu_dout, 0);
        check("rst_spr_ack", spr_ack, 0);
        check("rst_spr_data", spr_data, 0);
        check("rst_dma_ack", dma_ack, 0);
        check("rst_dma_data", dma_data, 0);
        check("rst_addr", asic_ram_addr, 0);
        check("rst_rd", asic_ram_rd, 0);
        check("rst_wr", asic_ram_wr, 0);
        check("rst_din", asic_ram_din, 0);
        cpu_rd = 1'b0; spr_req = 1'b0; dma_req = 3'b000;
        tick();
        reset = 1'b0;
        tick(); tick();

        // CPU read 0x4010: grant the cycle after the edge, data and wait release one later
        cpu_addr = 16'h4010; cpu_rd = 1'b1;
        #1;
        check("rd_edge_wait", cpu_wait, 1);
        check("rd_edge_rd", asic_ram_rd, 0);
        tick();
        check("rd_gnt_rd", asic_ram_rd, 1);
        check("rd_gnt_addr", asic_ram_addr, 14'h0010);
        check("rd_gnt_wait", cpu_wait, 1);
        tick();
        check("rd_done_wait", cpu_wait, 0);
        check("rd_done_dout", cpu_dout, 8'h5A);
        check("rd_done_rd", asic_ram_rd, 0);
        cpu_rd = 1'b0;
        tick();
        check("rd_hold_dout", cpu_dout, 8'h5A);

        // CPU write 0x7FFF = 0xC3
        cpu_addr = 16'h7FFF; cpu_din = 8'hC3; cpu_wr = 1'b1;
        #1;
        check("wr_edge_wait", cpu_wait, 1);
        tick();
        check("wr_gnt_wr", asic_ram_wr, 1);
        check("wr_gnt_rd", asic_ram_rd, 0);
        check("wr_gnt_addr", asic_ram_addr, 14'h3FFF);
        check("wr_gnt_din", asic_ram_din, 8'hC3);
        tick();
        check("wr_done_wr", asic_ram_wr, 0);
        check("wr_done_wait", cpu_wait, 0);
        check("wr_done_dout", cpu_dout, 8'h5A);
        check("wr_mem", mem[14'h3FFF], 8'hC3);
        cpu_wr = 1'b0;
        tick();

        // Locked or unmapped accesses never touch RAM nor stall the CPU
        asic_valid = 1'b0;
        tick();
        cpu_addr = 16'h4010; cpu_rd = 1'b1;
        for (int i = 0; i < 3; i++) begin #1; check_quiet("locked"); tick(); end
        cpu_rd = 1'b0; asic_valid = 1'b1; page_en = 1'b0;
        tick();
        cpu_rd = 1'b1;
        for (int i = 0; i < 3; i++) begin #1; check_quiet("nopage"); tick(); end
        cpu_rd = 1'b0; page_en = 1'b1;
        tick();
        cpu_addr = 16'h8000; cpu_rd = 1'b1;
        for (int i = 0; i < 2; i++) begin #1; check_quiet("above"); tick(); end
        cpu_rd = 1'b0;
        tick();
        cpu_addr = 16'h3FFF; cpu_rd = 1'b1;
        for (int i = 0; i < 2; i++) begin #1; check_quiet("below"); tick(); end
        cpu_rd = 1'b0;
        tick(); tick();

        // Sprite burst of 4, CPU forced in, sprite resumes
        spr_addr = 14'h2000; spr_req = 1'b1;
        for (int s = 0; s < 4; s++) begin
            #1;
            check("burst_spr_rd", asic_ram_rd, 1);
            check("burst_spr_addr", asic_ram_addr, 14'h2000);
            tick();
            if (s < 3) begin
                check("burst_spr_ack", spr_ack, 1);
                check("burst_spr_data", spr_data, 8'hA7);
                check("burst_gap_rd", asic_ram_rd, 0);
                tick();
            end
        end
        cpu_addr = 16'h4010; cpu_rd = 1'b1;
        #1;
        check("burst_s7_ack", spr_ack, 1);
        check("burst_s7_rd", asic_ram_rd, 0);
        check("burst_s7_wait", cpu_wait, 1);
        tick();
        check("burst_cpu_rd", asic_ram_rd, 1);
        check("burst_cpu_addr", asic_ram_addr, 14'h0010);
        check("burst_cpu_noack", spr_ack, 0);
        tick();
        cpu_rd = 1'b0;
        #1;
        check("burst_cpu_dout", cpu_dout, 8'h5A);
        check("burst_cpu_wait", cpu_wait, 0);
        check("burst_resume_rd", asic_ram_rd, 1);
        check("burst_resume_addr", asic_ram_addr, 14'h2000);
        tick();
        cpu_addr = 16'h4020; cpu_rd = 1'b1;
        #1;
        check("burst_resume_ack", spr_ack, 1);
        check("burst_resume_data", spr_data, 8'hA7);
        tick();
        check("short_spr_first", asic_ram_addr, 14'h2000);
        check("short_spr_rd", asic_ram_rd, 1);
        check("short_wait", cpu_wait, 1);
        tick();
        spr_req = 1'b0;
        #1;
        check("short_cpu_addr", asic_ram_addr, 14'h0020);
        check("short_cpu_rd", asic_ram_rd, 1);
        check("short_spr_ack", spr_ack, 1);
        tick();
        cpu_rd = 1'b0;
        #1;
        check("short_cpu_dout", cpu_dout, 8'h3C);
        check("short_cpu_wait", cpu_wait, 0);
        check("short_idle_rd", asic_ram_rd, 0);
        tick(); tick();

        // DMA round robin with all three channels held
        dma_addr = {14'h0300, 14'h0200, 14'h0100};
        dma_req  = 3'b111;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            #1;
            check("dma_rd", asic_ram_rd, 1);
            check("dma_addr", asic_ram_addr, dma_a[i % 3]);
            if (i > 0) begin
                check("dma_ack", dma_ack, 3'b001 << ((i - 1) % 3));
                check("dma_data", dma_data, dma_d[(i - 1) % 3]);
            end
        end
        tick();
        dma_req = 3'b000;
        #1;
        check("dma_last_ack", dma_ack, 3'b100);
        check("dma_last_rd", asic_ram_rd, 0);
        tick(); tick();

        // plus_mode drops with CPU pending behind an in-flight sprite read
        spr_req = 1'b1; cpu_addr = 16'h4010; cpu_rd = 1'b1;
        #1;
        check("drop_spr_rd", asic_ram_rd, 1);
        check("drop_edge_wait", cpu_wait, 1);
        tick();
        plus_mode = 1'b0;
        #1;
        check("drop_no_gnt", asic_ram_rd, 0);
        check("drop_spr_ack", spr_ack, 1);
        check("drop_spr_data", spr_data, 8'hA7);
        check("drop_wait_still", cpu_wait, 1);
        tick();
        check("drop_wait_low", cpu_wait, 0);
        check("drop_quiet_rd", asic_ram_rd, 0);
        check("drop_no_ack", spr_ack, 0);
        check("drop_dout", cpu_dout, 8'h3C);
        tick();
        plus_mode = 1'b1;
        #1;
        check("restore_spr_rd", asic_ram_rd, 1);
        check("restore_spr_addr", asic_ram_addr, 14'h2000);
        check("restore_wait", cpu_wait, 0);
        tick();
        spr_req = 1'b0; cpu_rd = 1'b0;
        #1;
        check("restore_ack", spr_ack, 1);
        check("restore_dout", cpu_dout, 8'h3C);
        tick(); tick();

        // Reset raised during a sprite grant cycle aborts the access
        spr_req = 1'b1;
        #1;
        check("rstg_rd_before", asic_ram_rd, 1);
        #2;
        reset = 1'b1;
        #1;
        check("rstg_rd_during", asic_ram_rd, 0);
        tick();
        reset = 1'b0; spr_req = 1'b0;
        #1;
        check("rstg_no_ack", spr_ack, 0);
        check("rstg_dout", cpu_dout, 0);
        check("rstg_wait", cpu_wait, 0);
        check("rstg_rd", asic_ram_rd, 0);
        check("rstg_dma_ack", dma_ack, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
